// File: rtl/dbg_frame_pkg.sv
// Shared constants, state encoding and byte helper for the debug-bridge
// frame sequencer.
package dbg_frame_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_WORDS = 63;
  localparam int unsigned WORDS_W   = $clog2(MAX_WORDS + 1);

  localparam logic [7:0] CMD_WRITE = 8'h10;
  localparam logic [7:0] CMD_READ  = 8'h11;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    ADDR,
    DATA
  } frame_state_e;

  // Byte idx of a 32-bit word, idx 0 = bits [7:0]
  function automatic logic [7:0] word_byte(input logic [DATA_W-1:0] w,
                                           input logic [1:0]        idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dbg_rr_arbiter.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module dbg_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant_c
);

  logic prio_q;  // 1: requester 1 wins a tie

  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      if (req == 2'b11) grant_c = prio_q ? 2'b10 : 2'b01;
      else              grant_c = req;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)          prio_q <= 1'b0;
    else if (|grant_c)  prio_q <= grant_c[0];
  end

endmodule

// File: rtl/dbg_frame_sequencer.sv
// Serializes word-level requests from two requesters into debug-bridge
// UART frames: CMD, LEN, ADDR (MSB first), DATA (LSB first per word).
module dbg_frame_sequencer
  import dbg_frame_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           req_valid_i,
  input  logic [1:0]           req_write_i,
  input  logic [2*ADDR_W-1:0]  req_addr_i,
  input  logic [2*WORDS_W-1:0] req_words_i,
  output logic [1:0]           req_ready_o,
  input  logic [2*DATA_W-1:0]  wdata_i,
  input  logic [1:0]           wdata_valid_i,
  output logic [1:0]           wdata_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_accept_i,
  output logic [1:0]           grant_o,
  output logic                 busy_o
);

  frame_state_e       state_q;
  logic               sel_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WORDS_W-1:0] words_q;
  logic [DATA_W-1:0]  hold_q;
  logic               hold_full_q;
  logic [1:0]         idx_q;

  logic [1:0]         grant_c;
  logic               sel_c;
  logic               req_write_c;
  logic [ADDR_W-1:0]  req_addr_c;
  logic [WORDS_W-1:0] req_words_c;
  logic [DATA_W-1:0]  wdata_c;
  logic               wdata_valid_c;
  logic               tx_fire_c;

  dbg_rr_arbiter u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req_valid_i),
    .en      (state_q == IDLE),
    .grant_c (grant_c)
  );

  // Request fields of the requester being granted, write data of the owner
  assign sel_c         = grant_c[1];
  assign req_write_c   = req_write_i[sel_c];
  assign req_addr_c    = sel_c ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
  assign req_words_c   = sel_c ? req_words_i[2*WORDS_W-1:WORDS_W] : req_words_i[WORDS_W-1:0];
  assign wdata_c       = sel_q ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
  assign wdata_valid_c = wdata_valid_i[sel_q];
  assign tx_fire_c     = tx_valid_o & tx_accept_i;

  // tx_data_o always holds the byte of the current state; it is reloaded
  // only when that byte is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      sel_q         <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      words_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      idx_q         <= 2'd0;
      req_ready_o   <= 2'b00;
      wdata_ready_o <= 2'b00;
      tx_data_o     <= 8'h00;
      tx_valid_o    <= 1'b0;
      grant_o       <= 2'b00;
      busy_o        <= 1'b0;
    end else begin
      req_ready_o <= 2'b00;
      case (state_q)
        IDLE: begin
          if (|grant_c) begin
            req_ready_o <= grant_c;
            grant_o     <= grant_c;
            busy_o      <= 1'b1;
            sel_q       <= sel_c;
            wr_q        <= req_write_c;
            addr_q      <= req_addr_c;
            words_q     <= req_words_c;
            tx_valid_o  <= 1'b1;
            tx_data_o   <= req_write_c ? CMD_WRITE : CMD_READ;
            state_q     <= CMD;
          end
        end
        CMD: begin
          if (tx_fire_c) begin
            tx_data_o <= {words_q, 2'b00};
            state_q   <= LEN;
          end
        end
        LEN: begin
          if (tx_fire_c) begin
            tx_data_o <= word_byte(addr_q, 2'd3);
            idx_q     <= 2'd0;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (tx_fire_c) begin
            if (idx_q == 2'd3) begin
              tx_valid_o <= 1'b0;
              idx_q      <= 2'd0;
              if (wr_q && (words_q != '0)) begin
                hold_full_q   <= 1'b0;
                wdata_ready_o <= sel_q ? 2'b10 : 2'b01;
                state_q       <= DATA;
              end else begin
                grant_o <= 2'b00;
                busy_o  <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              idx_q     <= idx_q + 2'd1;
              tx_data_o <= word_byte(addr_q, ~(idx_q + 2'd1));
            end
          end
        end
        DATA: begin
          if (!hold_full_q) begin
            if (wdata_valid_c && wdata_ready_o[sel_q]) begin
              hold_q        <= wdata_c;
              hold_full_q   <= 1'b1;
              wdata_ready_o <= 2'b00;
              tx_valid_o    <= 1'b1;
              tx_data_o     <= wdata_c[7:0];
              idx_q         <= 2'd0;
            end
          end else if (tx_fire_c) begin
            if (idx_q == 2'd3) begin
              tx_valid_o <= 1'b0;
              words_q    <= words_q - WORDS_W'(1);
              if (words_q == WORDS_W'(1)) begin
                grant_o <= 2'b00;
                busy_o  <= 1'b0;
                state_q <= IDLE;
              end else begin
                hold_full_q   <= 1'b0;
                wdata_ready_o <= sel_q ? 2'b10 : 2'b01;
              end
            end else begin
              idx_q     <= idx_q + 2'd1;
              tx_data_o <= word_byte(hold_q, idx_q + 2'd1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
